// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 hex keypad scanner.
package keypad_pkg;

  localparam int unsigned ROW_W  = 4;
  localparam int unsigned COL_W  = 4;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned CODE_W = 2 * IDX_W;
  localparam int unsigned NUM_W  = 32;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  // Index of the lowest active-low (zero) row bit; 0 when none is low.
  function automatic logic [IDX_W-1:0] low_zero(input logic [ROW_W-1:0] rows);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = ROW_W - 1; i >= 0; i--) begin
      if (!rows[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [CODE_W-1:0] make_code(input logic [IDX_W-1:0] row,
                                                  input logic [IDX_W-1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the active-low keypad rows; idles high.
module keypad_sync
  import keypad_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic [ROW_W-1:0] async_i,
  output logic [ROW_W-1:0] sync_o
);

  logic [ROW_W-1:0] meta_q;
  logic [ROW_W-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/keypad_hex_scanner.sv
// 4x4 keypad scanner with press/release debounce and an 8-digit hex shift register.
// Define KEYPAD_AUTO_REPEAT_EN to re-accept a held key every REPEAT_CYC cycles.
module keypad_hex_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CYC = 20000,
  parameter int unsigned REPEAT_CYC   = 5000000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ROW_W-1:0]  row_in,
  input  logic              clear,
  output logic [COL_W-1:0]  col_out,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic [NUM_W-1:0]  num_out
);

  localparam int unsigned MAX_AB  = (SCAN_DIV > DEBOUNCE_CYC) ? SCAN_DIV : DEBOUNCE_CYC;
  localparam int unsigned MAX_CYC = (MAX_AB > REPEAT_CYC) ? MAX_AB : REPEAT_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  logic [ROW_W-1:0]  rs;
  state_e            state_q, state_d;
  logic [IDX_W-1:0]  c_q, c_d, r_q, r_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              valid_q, valid_d;
  logic [NUM_W-1:0]  num_q, num_d;
  logic              accept;
  logic              rs_bit;

  keypad_sync u_sync (
    .clk     (clk),
    .resetn  (resetn),
    .async_i (row_in),
    .sync_o  (rs)
  );

  assign rs_bit = rs[r_q];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= SCAN;
      c_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      col_q   <= 4'b1110;
      code_q  <= '0;
      valid_q <= 1'b0;
      num_q   <= '0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      num_q   <= num_d;
    end
  end

  // Scan / debounce sequencing; accept marks the cycle a key is taken.
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      SCAN: begin
        if (rs != '1) begin
          r_d     = low_zero(rs);
          cnt_d   = '0;
          state_d = DEBOUNCE;
        end else if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
          cnt_d = '0;
          c_d   = c_q + 2'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DEBOUNCE: begin
        if (rs_bit) begin
          cnt_d   = '0;
          state_d = SCAN;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
          cnt_d   = '0;
          accept  = 1'b1;
          state_d = HELD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (rs_bit) begin
          cnt_d   = '0;
          state_d = RELEASE;
        end else begin
`ifdef KEYPAD_AUTO_REPEAT_EN
          if (cnt_q == CNT_W'(REPEAT_CYC - 1)) begin
            cnt_d  = '0;
            accept = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`else
          cnt_d = '0;
`endif
        end
      end
      RELEASE: begin
        if (!rs_bit) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
          cnt_d   = '0;
          c_d     = c_q + 2'd1;
          state_d = SCAN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = SCAN;
      end
    endcase
  end

  // Output register next values; clear has priority over the digit shift.
  always_comb begin
    col_d   = ~(COL_W'(1) << c_d);
    code_d  = code_q;
    valid_d = accept;
    num_d   = num_q;
    if (accept) begin
      code_d = make_code(r_q, c_q);
    end
    if (clear) begin
      num_d = '0;
    end else if (accept) begin
      num_d = {num_q[NUM_W-CODE_W-1:0], make_code(r_q, c_q)};
    end
  end

  assign col_out   = col_q;
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign num_out   = num_q;

endmodule

// File: tb/tb_keypad_hex_scanner.sv
// Randomized bench with a keypad model and an entry-level scoreboard of accepted keys.
module tb_keypad_hex_scanner;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DEB      = 8;
  localparam int unsigned REP      = 64;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        clear = 1'b0;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic [31:0] num_out;

  logic        pressed = 1'b0;
  logic [1:0]  prow = 2'd0;
  logic [1:0]  pcol = 2'd0;
  logic [3:0]  glitch = 4'h0;

  typedef struct packed {
    logic [3:0]  code;
    logic [31:0] num;
  } exp_t;

  exp_t        exp_q[$];
  int          chk_cnt = 0;
  int          pass_cnt = 0;
  int          pulse_cnt = 0;
  logic [31:0] model_num = 32'h0;

  always #5 clk = ~clk;

  // Physical keypad: a pressed key pulls its row low only while its column is driven.
  assign row_in = ((pressed && !col_out[pcol]) ? ~(4'b0001 << prow) : 4'hF) & ~glitch;

  keypad_hex_scanner #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CYC (DEB),
    .REPEAT_CYC   (REP)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .row_in    (row_in),
    .clear     (clear),
    .col_out   (col_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .num_out   (num_out)
  );

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %h want %h", name, act, req);
  endfunction

  // Each accepted key must match the next scoreboard entry.
  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      check("col_one_cold", 32'($countones(~col_out)), 32'd1);
      if (key_valid) begin
        pulse_cnt++;
        if (exp_q.size() == 0) begin
          check("key_valid_unexpected", {31'b0, key_valid}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("key_code", {28'b0, key_code}, {28'b0, e.code});
          check("num_out", num_out, e.num);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Accepted keys per hold: one, plus one per full repeat period held.
  function automatic int exp_pulses(input int hold);
`ifdef KEYPAD_AUTO_REPEAT_EN
    return 1 + hold / REP;
`else
    return 1;
`endif
  endfunction

  task automatic push_pulses(input logic [3:0] code, input int n, input bit clr);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      if (clr && i == 0) model_num = 32'h0;
      else model_num = {model_num[27:0], code};
      e.code = code;
      e.num  = model_num;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_key(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      tick(1);
      if (key_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Press a key at the start of its column window, hold, release, optionally bounce.
  task automatic press_key(input logic [3:0] code, input int hold, input bit clr, input bit bounce);
    bit ok;
    int n;
    int p0;
    n = exp_pulses(hold);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (col_out[code[1:0]]) begin ok = 1'b1; break; end
      tick(1);
    end
    check("col_leave_wait", 32'(ok), 32'd1);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (!col_out[code[1:0]]) begin ok = 1'b1; break; end
      tick(1);
    end
    check("col_enter_wait", 32'(ok), 32'd1);
    push_pulses(code, n, clr);
    p0 = pulse_cnt;
    prow = code[3:2];
    pcol = code[1:0];
    pressed = 1'b1;
    clear = clr;
    wait_key(ok);
    check("accept_wait", 32'(ok), 32'd1);
    clear = 1'b0;
    tick(hold);
    pressed = 1'b0;
    if (bounce) begin
      tick(4);
      pressed = 1'b1;
      tick(3);
      pressed = 1'b0;
    end
    tick(30);
    check("pulses_per_press", 32'(pulse_cnt - p0), 32'(n));
  endtask

  task automatic clear_idle();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    model_num = 32'h0;
    check("num_after_clear", num_out, 32'h0);
  endtask

  initial begin
    logic [3:0]  exp_col;
    logic [3:0]  c0;
    bit          ok;
    int          p0;
    int          hold;

    tick(3);
    check("rst_col_out", {28'b0, col_out}, 32'hE);
    check("rst_key_code", {28'b0, key_code}, 32'h0);
    check("rst_key_valid", {31'b0, key_valid}, 32'h0);
    check("rst_num_out", num_out, 32'h0);
    resetn = 1'b1;

    for (int k = 0; k < 16; k++) begin
      exp_col = ~(4'b0001 << ((k / 4) % 4));
      check("idle_col_seq", {28'b0, col_out}, {28'b0, exp_col});
      tick(1);
    end

    clear_idle();
    press_key(4'h9, 10, 1'b0, 1'b0);
    check("key9_num", num_out, 32'h9);
    check("key9_code", {28'b0, key_code}, 32'h9);

    clear_idle();
    for (int k = 1; k <= 9; k++) press_key(4'(k), 8, 1'b0, 1'b0);
    check("seq_num", num_out, 32'h23456789);

    glitch = 4'b0100;
    tick(5);
    glitch = 4'h0;
    tick(20);
    c0 = col_out;
    ok = 1'b0;
    for (int i = 0; i < 2 * SCAN_DIV; i++) begin
      tick(1);
      if (col_out != c0) begin ok = 1'b1; break; end
    end
    check("glitch_scan_resumes", 32'(ok), 32'd1);
    check("glitch_num", num_out, model_num);

    press_key(4'hA, 10, 1'b1, 1'b0);
    check("clr_accept_num", num_out, 32'h0);
    check("clr_accept_code", {28'b0, key_code}, 32'hA);

    p0 = pulse_cnt;
    press_key(4'h5, 200, 1'b0, 1'b0);
`ifdef KEYPAD_AUTO_REPEAT_EN
    check("hold200_pulses", 32'(pulse_cnt - p0), 32'd4);
`else
    check("hold200_pulses", 32'(pulse_cnt - p0), 32'd1);
`endif

    for (int t = 0; t < 25; t++) begin
`ifdef KEYPAD_AUTO_REPEAT_EN
      hold = int'($urandom_range(0, 2)) * int'(REP) + int'($urandom_range(8, 40));
`else
      hold = int'($urandom_range(5, 100));
`endif
      press_key(4'($urandom_range(0, 15)), hold, 1'b0, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 4) == 0) clear_idle();
    end

    // Reset during debounce aborts the key; the still-held key is found again.
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (col_out[2]) begin ok = 1'b1; break; end
      tick(1);
    end
    for (int i = 0; i < 64; i++) begin
      if (!col_out[2]) break;
      tick(1);
    end
    check("rst_press_col_wait", 32'(ok), 32'd1);
    prow = 2'd3;
    pcol = 2'd2;
    pressed = 1'b1;
    tick(5);
    resetn = 1'b0;
    exp_q.delete();
    model_num = 32'h0;
    tick(3);
    resetn = 1'b1;
    push_pulses(4'hE, 1, 1'b0);
    p0 = pulse_cnt;
    wait_key(ok);
    check("rst_redetect", 32'(ok), 32'd1);
    tick(5);
    pressed = 1'b0;
    tick(30);
    check("rst_redetect_pulses", 32'(pulse_cnt - p0), 32'd1);
    check("rst_redetect_num", num_out, 32'hE);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("final_num", num_out, model_num);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/keypad_hex_scanner.md
KEYPAD_HEX_SCANNER -- requirements
Module: keypad_hex_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, clk cycles each column is driven before advancing.
REQ-002 SHALL have parameter DEBOUNCE_CYC, default 20000, consecutive stable cycles required for press and for release.
REQ-003 SHALL have parameter REPEAT_CYC, default 5000000, auto-repeat period in cycles; used only under KEYPAD_AUTO_REPEAT_EN.
REQ-004 clk  input  1  system clock, all logic on rising edge.
REQ-005 resetn  input  1  reset, synchronous, active-low.
REQ-006 row_in  input  4  keypad rows, active-low, asynchronous, externally pulled up.
REQ-007 clear  input  1  synchronous clear of the accumulated number.
REQ-008 col_out  output  4  keypad column drive, active-low, one-cold.
REQ-009 key_code  output  4  hex code of the last accepted key.
REQ-010 key_valid  output  1  single-cycle strobe per accepted key.
REQ-011 num_out  output  32  accumulated entry of 8 hex digits, newest digit in [3:0].

Function
REQ-012 row_in SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value rs, giving 2 cycles of input latency.
REQ-013 FSM states SHALL be SCAN, DEBOUNCE, HELD, RELEASE.
REQ-014 In SCAN, col index c SHALL advance 0,1,2,3,0 every SCAN_DIV cycles; col_out = ~(4'b0001 << c).
REQ-015 In SCAN, if any bit of rs is 0, the FSM SHALL latch r = lowest-index zero bit, freeze c, clear the counter, and enter DEBOUNCE.
REQ-016 In DEBOUNCE, if rs[r] returns to 1, the FSM SHALL return to SCAN with c unchanged and emit no key.
REQ-017 If rs[r] stays 0 for DEBOUNCE_CYC cycles, the FSM SHALL enter HELD, pulse key_valid for 1 cycle, and set key_code = {r[1:0], c[1:0]}.
REQ-018 On that same cycle, num_out SHALL become {num_out[27:0], key_code_new}; the oldest digit is discarded (wrap by shifting out).
REQ-019 HELD SHALL persist while rs[r] = 0; on rs[r] = 1, the FSM SHALL enter RELEASE with the counter cleared.
REQ-020 In RELEASE, any cycle with rs[r] = 0 SHALL restart the count; DEBOUNCE_CYC consecutive cycles with rs[r] = 1 SHALL return the FSM to SCAN with c advanced by 1.
REQ-021 Other keys pressed during DEBOUNCE, HELD, or RELEASE SHALL be ignored; col_out stays frozen.
REQ-022 clear = 1 SHALL set num_out to 0 next cycle; if a key is accepted on the same cycle, clear wins for num_out, while key_valid and key_code still update.
REQ-023 Counters SHALL be wide enough for max(SCAN_DIV, DEBOUNCE_CYC, REPEAT_CYC) and SHALL never wrap within a state.

Reset
REQ-024 While resetn = 0 at a clk edge: state SCAN, c = 0, col_out = 4'b1110, key_code = 0, key_valid = 0, num_out = 0, synchronizer = 4'hF, counters = 0.
REQ-025 Reset asserted mid-press SHALL abort the key without a key_valid; after release, a still-held key is re-detected from SCAN.

Configuration
REQ-026 With KEYPAD_AUTO_REPEAT_EN defined, HELD SHALL re-accept the same key (key_valid pulse plus shift) after REPEAT_CYC cycles held, and every REPEAT_CYC cycles thereafter.
REQ-027 Without KEYPAD_AUTO_REPEAT_EN, one hold SHALL produce exactly one key_valid, and the REPEAT_CYC logic SHALL be absent.

Structure
REQ-028 Package keypad_pkg SHALL hold the FSM state typedef (SCAN, DEBOUNCE, HELD, RELEASE) and the key-code construction constant widths.
REQ-029 The synchronizer SHALL be the sub-module keypad_sync (4-bit, 2-flop, reset value 4'hF).

Verification (SCAN_DIV=4, DEBOUNCE_CYC=8, REPEAT_CYC=64)
REQ-030 Reset then idle rows 4'hF -> col_out cycles 1110, 1101, 1011, 0111, changing every 4 cycles; key_valid never asserts.
REQ-031 Row 2 held low while column 1 is driven, for 20 cycles -> exactly one key_valid, key_code = 4'h9, num_out = 32'h9.
REQ-032 Keys 1, 2, 3, 4, 5, 6, 7, 8, 9 entered in sequence -> num_out = 32'h23456789 (digit 1 shifted out).
REQ-033 Row glitch low for 5 cycles -> no key_valid; FSM returns to SCAN.
REQ-034 clear asserted on the key_valid cycle of key 4'hA -> num_out = 0, key_code = 4'hA.
REQ-035 Key held for 200 cycles -> with KEYPAD_AUTO_REPEAT_EN, 1 + 3 pulses; without it, 1 pulse.
